jtframe_pocket_i2s: RTL

//  Serialises board_left/board_right into Pocket I2S (MCLK 256fs, SCLK 64fs, LRCK fs, DAT).

---
 rtl/jtframe_pocket_i2s_pkg.sv | 29 ++
 rtl/jtframe_pocket_i2s_if.sv | 24 ++
 rtl/jtframe_frac_cen.sv | 29 ++
 rtl/jtframe_pocket_i2s.sv | 112 +++++++++++
 4 files changed

// File: rtl/jtframe_pocket_i2s_pkg.sv
// Shared constants, types and sample helpers for the Pocket I2S audio output.
package jtframe_pocket_i2s_pkg;

    localparam int unsigned I2S_SLOT  = 32;
    localparam int unsigned I2S_FRAME = 64;
    localparam int unsigned I2S_SW    = 16;
    localparam int unsigned DIV_SCLK  = 8;
    localparam int unsigned BCNT_W    = $clog2(I2S_FRAME);
    localparam int unsigned DIV_W     = $clog2(DIV_SCLK);

    typedef logic [I2S_SW-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } pair_t;

    // Unsigned audio is offset binary; flipping the MSB recentres it on zero.
    function automatic sample_t to_twos(input sample_t s, input logic is_signed);
        return is_signed ? s : {~s[I2S_SW-1], s[I2S_SW-2:0]};
    endfunction

    function automatic sample_t mono_mix(input sample_t l, input sample_t r);
        logic signed [I2S_SW:0] sum;
        sum = $signed({l[I2S_SW-1], l}) + $signed({r[I2S_SW-1], r});
        return sample_t'(sum >>> 1);
    endfunction

endpackage

// File: rtl/jtframe_pocket_i2s_if.sv
// Sample input and I2S output bundle between the board audio path and the Pocket pins.
interface jtframe_pocket_i2s_if;
    import jtframe_pocket_i2s_pkg::*;

    sample_t snd_left;
    sample_t snd_right;
    logic    snd_sample;
    logic    i2s_mclk;
    logic    i2s_sclk;
    logic    i2s_lrck;
    logic    i2s_dat;
    logic    smp_drop;

    modport master (
        output snd_left, snd_right, snd_sample,
        input  i2s_mclk, i2s_sclk, i2s_lrck, i2s_dat, smp_drop
    );

    modport slave (
        input  snd_left, snd_right, snd_sample,
        output i2s_mclk, i2s_sclk, i2s_lrck, i2s_dat, smp_drop
    );

endinterface

// File: rtl/jtframe_frac_cen.sv
// Fractional clock enable: cen_o fires at clk_sys * NUM / DEN on average.
module jtframe_frac_cen #(
    parameter int unsigned NUM = 64,
    parameter int unsigned DEN = 125,
    parameter int unsigned CW  = 8
) (
    input  logic clk_sys,
    input  logic rst_n,
    output logic cen_o
);

    logic [CW-1:0] acc_q, acc_d;
    logic [CW:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + (CW+1)'(NUM);
        cen_o = (sum >= (CW+1)'(DEN));
        acc_d = cen_o ? CW'(sum - (CW+1)'(DEN)) : sum[CW-1:0];
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/jtframe_pocket_i2s.sv
// Pocket I2S serialiser (MCLK 256fs, SCLK 64fs, LRCK fs) fed from the board audio samples.
// Define JTFRAME_I2S_MONO_EN to send (L+R)/2 on both channels.
module jtframe_pocket_i2s
    import jtframe_pocket_i2s_pkg::*;
#(
    parameter bit          SIGNED_SND = 1'b0,
    parameter int unsigned MCLK_NUM   = 64,
    parameter int unsigned MCLK_DEN   = 125,
    parameter int unsigned CW         = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    jtframe_pocket_i2s_if.slave   aud_io
);

    logic                      mtick;
    logic                      mclk_q, mclk_d;
    logic                      sclk_q, sclk_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [BCNT_W-1:0]         bcnt_q, bcnt_d;
    logic                      lrck_q, lrck_d;
    logic                      dat_q, dat_d;
    logic [I2S_FRAME-1:0]      shift_q, shift_d;
    pair_t                     hold_q, hold_d;
    logic                      pend_q, pend_d;
    logic                      smp_q;
    logic                      drop_q, drop_d;
    logic                      sclk_tgl, shift_pt, frame_end, smp_rise;
    sample_t                   cap_l, cap_r;

    jtframe_frac_cen #(
        .NUM (MCLK_NUM),
        .DEN (MCLK_DEN),
        .CW  (CW)
    ) u_cen (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .cen_o   (mtick)
    );

    // SCLK toggles every DIV_SCLK/2 mticks; its falling edge lands on the divider wrap.
    assign sclk_tgl  = mtick && (div_q[DIV_W-2:0] == '1);
    assign shift_pt  = mtick && (div_q == '1);
    assign frame_end = shift_pt && (bcnt_q == '1);
    assign smp_rise  = aud_io.snd_sample && !smp_q;

    always_comb begin
        cap_l = to_twos(aud_io.snd_left, SIGNED_SND);
        cap_r = to_twos(aud_io.snd_right, SIGNED_SND);
`ifdef JTFRAME_I2S_MONO_EN
        cap_l = mono_mix(cap_l, cap_r);
        cap_r = cap_l;
`endif
    end

    always_comb begin
        mclk_d  = mclk_q ^ mtick;
        sclk_d  = sclk_q ^ sclk_tgl;
        div_d   = div_q + DIV_W'(mtick);
        bcnt_d  = bcnt_q;
        lrck_d  = lrck_q;
        dat_d   = dat_q;
        shift_d = shift_q;
        if (shift_pt) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            lrck_d = bcnt_d[BCNT_W-1];
            dat_d  = shift_q[I2S_FRAME-1];
            // Holding always carries the last captured pair, so an underrun repeats it.
            shift_d = frame_end
                ? {hold_q.left, {(I2S_SLOT-I2S_SW){1'b0}}, hold_q.right, {(I2S_SLOT-I2S_SW){1'b0}}}
                : shift_q << 1;
        end
        hold_d = smp_rise ? {cap_l, cap_r} : hold_q;
        pend_d = smp_rise || (pend_q && !frame_end);
        drop_d = smp_rise && pend_q && !frame_end;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mclk_q  <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bcnt_q  <= '0;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            shift_q <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            smp_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            mclk_q  <= mclk_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            smp_q   <= aud_io.snd_sample;
            drop_q  <= drop_d;
        end
    end

    assign aud_io.i2s_mclk = mclk_q;
    assign aud_io.i2s_sclk = sclk_q;
    assign aud_io.i2s_lrck = lrck_q;
    assign aud_io.i2s_dat  = dat_q;
    assign aud_io.smp_drop = drop_q;

endmodule
